// File: rtl/ripple_down_counter_sync_pkg.sv
// Shared constants for the synchronous toggle-cell down counter family.
package ripple_down_counter_sync_pkg;

  // Default counter width in bits (legal range 2..16)
  localparam int DEFAULT_WIDTH = 4;

  // Terminal value reached when a wrapping counter underflows from 0
  localparam logic [DEFAULT_WIDTH-1:0] ALL_ONES = {DEFAULT_WIDTH{1'b1}};

  // Underflow behaviour selector
  localparam bit MODE_WRAP = 1'b1;
  localparam bit MODE_STOP = 1'b0;

endpackage

// File: rtl/ripple_down_counter_sync_if.sv
// Control/status bundle of one down-counter stage.
interface ripple_down_counter_sync_if
  import ripple_down_counter_sync_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             count_en;
  logic [WIDTH-1:0] q;
  logic             zero;
  logic             borrow;
  logic             done;

  // Controller side: drives load/data/enable, observes count and flags
  modport master (
    output load, din, count_en,
    input  q, zero, borrow, done
  );

  // Counter side
  modport slave (
    input  load, din, count_en,
    output q, zero, borrow, done
  );
endinterface

// File: rtl/ripple_down_counter_sync_t_cell.sv
// Synchronous T flip-flop with parallel load; load wins over toggle.
module t_cell_sync (
  input  logic clk,
  input  logic reset,
  input  logic t,
  input  logic load,
  input  logic d,
  output logic q
);

  // Cell state: clear on reset, load d, else toggle when t is high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 1'b0;
    end else if (load) begin
      q <= d;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/ripple_down_counter_sync.sv
// WIDTH-bit synchronous down counter built from toggle cells sharing one
// clock. Bit i toggles when a decrement is accepted and all lower bits are 0.
module ripple_down_counter_sync
  import ripple_down_counter_sync_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter bit WRAP  = MODE_WRAP
) (
  input  logic                         clk,
  input  logic                         reset,
  ripple_down_counter_sync_if.slave    bus
);

  logic [WIDTH-1:0] q_bits;
  logic [WIDTH-1:0] t_bits;
  logic             step;          // decrement requested and not overridden by load
  logic             q_is_zero;
  logic             hold_at_zero;  // stop mode freezes the count at 0

  assign step         = bus.count_en & ~bus.load;
  assign q_is_zero    = (q_bits == '0);
  assign hold_at_zero = (WRAP == MODE_STOP) & q_is_zero;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      if (gi == 0) begin : g_lsb
        // LSB flips on every accepted decrement
        assign t_bits[gi] = step & ~hold_at_zero;
      end else begin : g_upper
        // A borrow propagates into bit gi only when everything below is 0
        assign t_bits[gi] = step & ~hold_at_zero & (q_bits[gi-1:0] == '0);
      end

      t_cell_sync u_cell (
        .clk   (clk),
        .reset (reset),
        .t     (t_bits[gi]),
        .load  (bus.load),
        .d     (bus.din[gi]),
        .q     (q_bits[gi])
      );
    end
  endgenerate

  assign bus.q      = q_bits;
  assign bus.zero   = q_is_zero;
  // Next stage must decrement on the same edge this stage wraps to all ones
  assign bus.borrow = step & q_is_zero & (WRAP == MODE_WRAP);

  generate
    if (WRAP == MODE_STOP) begin : g_done
      logic done_reg;

      // Sticky terminal flag: set on a counted 1->0 step, cleared by load
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          done_reg <= 1'b0;
        end else if (bus.load) begin
          done_reg <= 1'b0;
        end else if (step && (q_bits == WIDTH'(1))) begin
          done_reg <= 1'b1;
        end
      end

      assign bus.done = done_reg;
    end else begin : g_no_done
      assign bus.done = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_ripple_down_counter_sync.sv
// Bench for the down counter: wrap instance (also low stage of a cascade),
// high cascade stage, and a stop-at-zero instance, all against a model.
module tb_ripple_down_counter_sync;
  import ripple_down_counter_sync_pkg::*;

  logic clk;
  logic reset;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  // Reference state: [0] wrap instance, [1] stop instance; mh is high stage
  int mq [2];
  int md [2];
  int mh;

  ripple_down_counter_sync_if #(.WIDTH(4)) if_w ();
  ripple_down_counter_sync_if #(.WIDTH(4)) if_h ();
  ripple_down_counter_sync_if #(.WIDTH(4)) if_s ();

  assign if_h.count_en = if_w.borrow;

  ripple_down_counter_sync #(.WIDTH(4), .WRAP(MODE_WRAP)) dut_w (
    .clk (clk), .reset (reset), .bus (if_w)
  );
  ripple_down_counter_sync #(.WIDTH(4), .WRAP(MODE_WRAP)) dut_h (
    .clk (clk), .reset (reset), .bus (if_h)
  );
  ripple_down_counter_sync #(.WIDTH(4), .WRAP(MODE_STOP)) dut_s (
    .clk (clk), .reset (reset), .bus (if_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    else
      pass_cnt++;
  endtask

  // Behavioural rule set: load > count > hold, wrap or stop at 0
  function automatic void step_model(int k, bit ld, int d, bit en, bit wrap);
    if (ld) begin
      mq[k] = d;
      md[k] = 0;
    end else if (en) begin
      if (mq[k] != 0) begin
        if (!wrap && mq[k] == 1) md[k] = 1;
        mq[k] = mq[k] - 1;
      end else if (wrap) begin
        mq[k] = int'(ALL_ONES);
      end
    end
  endfunction

  task automatic cycle();
    bit lo_borrow;
    @(posedge clk);
    lo_borrow = if_w.count_en && !if_w.load && (mq[0] == 0);
    if (if_h.load)      mh = int'(if_h.din);
    else if (lo_borrow) mh = (mh == 0) ? 15 : mh - 1;
    step_model(0, if_w.load, int'(if_w.din), if_w.count_en, 1'b1);
    step_model(1, if_s.load, int'(if_s.din), if_s.count_en, 1'b0);
    #1;
    cyc++;
    $display("cyc %0d: w_q=%0d h_q=%0d s_q=%0d s_done=%0b", cyc, if_w.q, if_h.q, if_s.q, if_s.done);
  endtask

  task automatic check_all();
    #1;
    check("w_q",      32'(if_w.q),      32'(mq[0]));
    check("w_zero",   32'(if_w.zero),   32'(mq[0] == 0));
    check("w_borrow", 32'(if_w.borrow), 32'(if_w.count_en && !if_w.load && mq[0] == 0));
    check("w_done",   32'(if_w.done),   32'(0));
    check("h_q",      32'(if_h.q),      32'(mh));
    check("s_q",      32'(if_s.q),      32'(mq[1]));
    check("s_zero",   32'(if_s.zero),   32'(mq[1] == 0));
    check("s_borrow", 32'(if_s.borrow), 32'(0));
    check("s_done",   32'(if_s.done),   32'(md[1]));
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    #1 reset = 1'b0;
    #1;
    mq[0] = 0; mq[1] = 0; md[0] = 0; md[1] = 0; mh = 0;
    check("rst_w_q",    32'(if_w.q),    32'(0));
    check("rst_w_zero", 32'(if_w.zero), 32'(1));
    check("rst_s_done", 32'(if_s.done), 32'(0));
    check("rst_h_q",    32'(if_h.q),    32'(0));
    #1 reset = 1'b1;
  endtask

  task automatic set_w(bit ld, int d, bit en);
    if_w.load = ld; if_w.din = 4'(d); if_w.count_en = en;
  endtask

  task automatic set_s(bit ld, int d, bit en);
    if_s.load = ld; if_s.din = 4'(d); if_s.count_en = en;
  endtask

  initial begin
    reset = 1'b0;
    set_w(0, 0, 0);
    set_s(0, 0, 0);
    if_h.load = 1'b0;
    if_h.din  = 4'd0;
    mq[0] = 0; mq[1] = 0; md[0] = 0; md[1] = 0; mh = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b1;

    // 1. reset mid-operation at q=9, then wrap sequence
    set_w(1, 10, 0); cycle(); check_all();
    set_w(0, 0, 1);  cycle(); check_all();
    check("q_is_9", 32'(if_w.q), 32'(9));
    do_reset();
    set_w(0, 0, 1);
    check_all();
    check("borrow_pre", 32'(if_w.borrow), 32'(1));
    for (int i = 0; i < 17; i++) begin
      cycle(); check_all();
    end
    check("wrap_15", 32'(if_w.q), 32'(15));

    // 2. load beats count_en
    set_w(1, 5, 0);  cycle(); check_all();
    set_w(1, 12, 1); cycle(); check_all();
    check("load_prio", 32'(if_w.q), 32'(12));
    set_w(0, 0, 1);  cycle(); check_all();
    check("after_load", 32'(if_w.q), 32'(11));

    // 3. pause at 7, resume
    set_w(1, 10, 0); cycle(); check_all();
    set_w(0, 0, 1);
    repeat (3) begin cycle(); check_all(); end
    set_w(0, 0, 0);
    repeat (3) begin cycle(); check_all(); end
    check("paused", 32'(if_w.q), 32'(7));
    set_w(0, 0, 1);
    repeat (2) begin cycle(); check_all(); end
    check("resumed", 32'(if_w.q), 32'(5));
    set_w(0, 0, 0);

    // 4. stop mode and sticky done
    set_s(1, 2, 0); cycle(); check_all();
    set_s(0, 0, 1);
    repeat (5) begin cycle(); check_all(); end
    check("stop_q",    32'(if_s.q),    32'(0));
    check("stop_done", 32'(if_s.done), 32'(1));
    set_s(1, 0, 1); cycle(); check_all();
    check("done_clr",  32'(if_s.done), 32'(0));
    set_s(0, 0, 0);

    // 5. cascade 0x00 -> 0xFF -> 0xFE, and 0x10 -> 0x0F
    set_w(1, 0, 0); if_h.load = 1'b1; if_h.din = 4'd0;
    cycle(); check_all();
    if_h.load = 1'b0; set_w(0, 0, 1);
    cycle(); check_all();
    check("casc_ff", 32'({if_h.q, if_w.q}), 32'(8'hFF));
    cycle(); check_all();
    check("casc_fe", 32'({if_h.q, if_w.q}), 32'(8'hFE));
    set_w(1, 0, 0); if_h.load = 1'b1; if_h.din = 4'd1;
    cycle(); check_all();
    if_h.load = 1'b0; set_w(0, 0, 1);
    cycle(); check_all();
    check("casc_0f", 32'({if_h.q, if_w.q}), 32'(8'h0F));

    // 6. random regression
    for (int i = 0; i < 1000; i++) begin
      set_w($urandom_range(0, 7) == 0, int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      set_s($urandom_range(0, 9) == 0, int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      if_h.load = ($urandom_range(0, 15) == 0);
      if_h.din  = 4'($urandom_range(0, 15));
      check_all();
      cycle();
      if ($urandom_range(0, 199) == 0) do_reset();
      check_all();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
